// File: rtl/stopwatch_key_ctrl_if.sv
// Key inputs and timer-control outputs of the stopwatch key controller.
// The controller side is the master; the board or timer side is the slave.
interface stopwatch_key_ctrl_if;
  logic       key_start;
  logic       key_stop;
  logic       key_clr;
  logic       start;
  logic       stop;
  logic       clr;
  logic [1:0] state_led;

  modport master (
    input  key_start, key_stop, key_clr,
    output start, stop, clr, state_led
  );

  modport slave (
    output key_start, key_stop, key_clr,
    input  start, stop, clr, state_led
  );
endinterface

// File: rtl/stopwatch_key_ctrl.sv
// Debounces start/stop/clear buttons and runs the run/pause/clear FSM that
// drives the level inputs of the mod-99 seconds timer.
module stopwatch_key_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1_000_000,
  parameter int unsigned CLR_HOLD_CYCLES = 32'd110_000_000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  stopwatch_key_ctrl_if.master ctrl
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 32'd1;
  localparam int unsigned HOLD_W = (CLR_HOLD_CYCLES > 32'd1) ? $clog2(CLR_HOLD_CYCLES) : 32'd1;
  localparam logic [DB_W-1:0]   DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(CLR_HOLD_CYCLES - 32'd1);
  localparam logic [2:0]        RAW_RELEASED = KEY_ACTIVE_LOW ? 3'b111 : 3'b000;
  localparam int                KEY_START    = 32'sd0;
  localparam int                KEY_STOP     = 32'sd1;
  localparam int                KEY_CLR      = 32'sd2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    CLEAR = 2'b11
  } state_t;

  // Timer drive levels {start, stop, clr} for each state.
  function automatic logic [2:0] outs_of(input state_t s);
    case (s)
      IDLE:    return 3'b000;
      RUN:     return 3'b100;
      PAUSE:   return 3'b110;
      CLEAR:   return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  logic [2:0]        raw_s;
  logic [2:0]        sync1_r;
  logic [2:0]        sync2_r;
  logic [2:0]        pressed_s;
  logic [2:0]        level_r;
  logic [2:0]        press_ev_r;
  logic [DB_W-1:0]   db_cnt_r [3];
  state_t            state_r;
  logic [HOLD_W-1:0] hold_r;
  logic              start_r;
  logic              stop_r;
  logic              clr_r;

  assign raw_s     = {ctrl.key_clr, ctrl.key_stop, ctrl.key_start};
  assign pressed_s = sync2_r ^ RAW_RELEASED;

  // Two-flop synchronisers, per-key debounce counters and press-event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r    <= RAW_RELEASED;
      sync2_r    <= RAW_RELEASED;
      level_r    <= 3'b000;
      press_ev_r <= 3'b000;
      for (int k = 32'sd0; k < 32'sd3; k++) begin
        db_cnt_r[k] <= '0;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      for (int k = 32'sd0; k < 32'sd3; k++) begin
        if (pressed_s[k] != level_r[k]) begin
          if (db_cnt_r[k] == DB_LAST) begin
            level_r[k]    <= pressed_s[k];
            press_ev_r[k] <= pressed_s[k];
            db_cnt_r[k]   <= '0;
          end else begin
            press_ev_r[k] <= 1'b0;
            db_cnt_r[k]   <= db_cnt_r[k] + DB_W'(1);
          end
        end else begin
          press_ev_r[k] <= 1'b0;
          db_cnt_r[k]   <= '0;
        end
      end
    end
  end

  // Run/pause/clear FSM with registered timer outputs; clr outranks stop outranks start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r                   <= IDLE;
      hold_r                    <= '0;
      {start_r, stop_r, clr_r}  <= 3'b000;
    end else begin
      case (state_r)
        IDLE: begin
          if (press_ev_r[KEY_CLR]) begin
            state_r                  <= CLEAR;
            hold_r                   <= '0;
            {start_r, stop_r, clr_r} <= outs_of(CLEAR);
          end else if (press_ev_r[KEY_START]) begin
            state_r                  <= RUN;
            {start_r, stop_r, clr_r} <= outs_of(RUN);
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (press_ev_r[KEY_CLR]) begin
            state_r                  <= CLEAR;
            hold_r                   <= '0;
            {start_r, stop_r, clr_r} <= outs_of(CLEAR);
          end else if (press_ev_r[KEY_STOP]) begin
            state_r                  <= PAUSE;
            {start_r, stop_r, clr_r} <= outs_of(PAUSE);
          end else begin
            state_r <= RUN;
          end
        end
        PAUSE: begin
          if (press_ev_r[KEY_CLR]) begin
            state_r                  <= CLEAR;
            hold_r                   <= '0;
            {start_r, stop_r, clr_r} <= outs_of(CLEAR);
          end else if (press_ev_r[KEY_START]) begin
            state_r                  <= RUN;
            {start_r, stop_r, clr_r} <= outs_of(RUN);
          end else begin
            state_r <= PAUSE;
          end
        end
        CLEAR: begin
          // Key events are dropped here so clr spans at least one timer tick.
          if (hold_r == HOLD_LAST) begin
            state_r                  <= IDLE;
            hold_r                   <= '0;
            {start_r, stop_r, clr_r} <= outs_of(IDLE);
          end else begin
            hold_r <= hold_r + HOLD_W'(1);
          end
        end
        default: begin
          state_r                  <= IDLE;
          hold_r                   <= '0;
          {start_r, stop_r, clr_r} <= outs_of(IDLE);
        end
      endcase
    end
  end

  assign ctrl.start     = start_r;
  assign ctrl.stop      = stop_r;
  assign ctrl.clr       = clr_r;
  assign ctrl.state_led = state_r;

endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// Directed bench for stopwatch_key_ctrl: a window-based debounce model plus a
// state-table FSM model are compared against the outputs every cycle.
module tb_stopwatch_key_ctrl;
  localparam int DB   = 8;
  localparam int HOLD = 20;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    checks = 0;
  int    errors = 0;
  string phase = "init";

  stopwatch_key_ctrl_if ifc ();

  stopwatch_key_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .CLR_HOLD_CYCLES(HOLD),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (ifc)
  );

  always #5 clk = ~clk;

  // Model: hist[k] bit i = key k pressed at the posedge i edges ago.
  bit [15:0] hist [3];
  bit [2:0]  m_acc;
  bit [2:0]  m_ev;
  int        m_state;   // 0 idle, 1 run, 2 pause, 3 clear
  int        m_elapsed;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) hist[k] = '0;
    m_acc = '0;
    m_ev = '0;
    m_state = 0;
    m_elapsed = 0;
  endtask

  task automatic model_step();
    bit [2:0] raw;
    bit [2:0] new_ev;
    bit       all_diff;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_state)
      0: if (m_ev[2]) begin m_state = 3; m_elapsed = 1; end
         else if (m_ev[0]) m_state = 1;
      1: if (m_ev[2]) begin m_state = 3; m_elapsed = 1; end
         else if (m_ev[1]) m_state = 2;
      2: if (m_ev[2]) begin m_state = 3; m_elapsed = 1; end
         else if (m_ev[0]) m_state = 1;
      default: if (m_elapsed == HOLD) m_state = 0; else m_elapsed++;
    endcase
    raw = {ifc.key_clr, ifc.key_stop, ifc.key_start};
    new_ev = '0;
    for (int k = 0; k < 3; k++) begin
      hist[k] = {hist[k][14:0], ~raw[k]};
      // Accept once the DB synced samples (2 edges of sync delay) all disagree.
      all_diff = 1'b1;
      for (int i = 2; i <= DB + 1; i++) if (hist[k][i] == m_acc[k]) all_diff = 1'b0;
      if (all_diff) begin
        m_acc[k] = ~m_acc[k];
        new_ev[k] = m_acc[k];
      end
    end
    m_ev = new_ev;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check({phase, ".start"}, int'(ifc.start), int'(m_state != 0));
    check({phase, ".stop"}, int'(ifc.stop), int'(m_state == 2));
    check({phase, ".clr"}, int'(ifc.clr), int'(m_state == 3));
    check({phase, ".led"}, int'(ifc.state_led), m_state);
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_keys(input bit s, input bit p, input bit c);
    ifc.key_start = ~s;
    ifc.key_stop  = ~p;
    ifc.key_clr   = ~c;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int  lat;
  int  rises;
  int  clr_cycles;
  bit  found;
  bit  prev_start;

  initial begin
    set_keys(1'b0, 1'b0, 1'b0);
    model_reset();

    // 1: idle after reset
    phase = "t1";
    do_reset();
    rises = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ifc.start) rises++;
    end
    check("t1.no_start", rises, 0);
    check("t1.led_idle", int'(ifc.state_led), 0);

    // 2: single clean press -> RUN after sync + debounce + FSM edge
    phase = "t2";
    set_keys(1'b1, 1'b0, 1'b0);
    found = 1'b0; lat = -1; rises = 0; prev_start = ifc.start;
    for (int i = 1; i <= 32; i++) begin
      if (i == 13) set_keys(1'b0, 1'b0, 1'b0);
      tick();
      if (!found && ifc.start) begin found = 1'b1; lat = i; end
      if (ifc.start && !prev_start) rises++;
      prev_start = ifc.start;
    end
    check("t2.latency", lat, 11);
    check("t2.one_event", rises, 1);

    // 3: bouncing key, then stable press
    phase = "t3";
    do_reset();
    rises = 0; prev_start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      set_keys(((i / 3) % 2) == 0, 1'b0, 1'b0);
      tick();
      if (ifc.start && !prev_start) rises++;
      prev_start = ifc.start;
    end
    check("t3.none_while_bouncing", rises, 0);
    set_keys(1'b1, 1'b0, 1'b0);
    found = 1'b0; lat = -1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (!found && ifc.start) begin found = 1'b1; lat = i; end
      if (ifc.start && !prev_start) rises++;
      prev_start = ifc.start;
    end
    check("t3.one_run", rises, 1);
    check("t3.latency_after_stable", lat, 11);
    set_keys(1'b0, 1'b0, 1'b0);
    ticks(15);

    // 4: RUN -> PAUSE -> RUN
    phase = "t4";
    set_keys(1'b0, 1'b1, 1'b0);
    ticks(12);
    set_keys(1'b0, 1'b0, 1'b0);
    ticks(5);
    check("t4.pause_start", int'(ifc.start), 1);
    check("t4.pause_stop", int'(ifc.stop), 1);
    check("t4.pause_led", int'(ifc.state_led), 2);
    set_keys(1'b1, 1'b0, 1'b0);
    ticks(12);
    set_keys(1'b0, 1'b0, 1'b0);
    ticks(5);
    check("t4.run_stop", int'(ifc.stop), 0);
    check("t4.run_led", int'(ifc.state_led), 1);

    // 5: clear held exactly HOLD cycles, then IDLE
    phase = "t5";
    set_keys(1'b0, 1'b0, 1'b1);
    clr_cycles = 0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 13) set_keys(1'b0, 1'b0, 1'b0);
      tick();
      if (ifc.clr) clr_cycles++;
    end
    check("t5.clr_cycles", clr_cycles, 20);
    check("t5.idle_start", int'(ifc.start), 0);
    check("t5.idle_led", int'(ifc.state_led), 0);

    // 6: simultaneous stop+clr in RUN -> CLEAR, then async reset mid-CLEAR
    phase = "t6";
    set_keys(1'b1, 1'b0, 1'b0);
    ticks(12);
    set_keys(1'b0, 1'b0, 1'b0);
    ticks(5);
    check("t6.in_run", int'(ifc.state_led), 1);
    set_keys(1'b0, 1'b1, 1'b1);
    ticks(12);
    set_keys(1'b0, 1'b0, 1'b0);
    ticks(5);
    check("t6.clear_led", int'(ifc.state_led), 3);
    check("t6.clear_stop", int'(ifc.stop), 0);
    check("t6.clear_clr", int'(ifc.clr), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6.async_clr", int'(ifc.clr), 0);
    check("t6.async_led", int'(ifc.state_led), 0);
    check("t6.async_start", int'(ifc.start), 0);
    ticks(2);
    rst_n = 1'b1;
    ticks(30);
    check("t6.stays_idle", int'(ifc.state_led), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
